if_fetch_buffer: RTL and testbench

Instruction fetch buffer between the PC/ROM fetch path and the ID stage. It pairs each instruction returned by the synchronous ROM with the PC that fetched it and queues the pairs in a small FIFO. It presents the head entry to ID with a valid/stall handshake and drives `stall_pc` so the PC never runs ahead of free buffer space. A `flush` input discards queued and in-flight fetches.

---
 rtl/if_fetch_buffer_pkg.sv | 12 +
 rtl/if_fetch_buffer_fifo.sv | 84 ++++++++
 rtl/if_fetch_buffer.sv | 102 ++++++++++
 tb/tb_if_fetch_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared constants for the instruction fetch buffer.
// Bus widths, the zero word, and the active-low reset / chip-enable levels.
package if_fetch_buffer_pkg;

  localparam int unsigned ADDR_BUS     = 32;
  localparam int unsigned INST_BUS     = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        RST_ENABLE   = 1'b0;  // reset is active low
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// fetch_fifo: DEPTH x W storage for {pc, inst} fetch entries.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    write one entry at the tail
//   pop_i             drop the head entry (ignored when empty)
//   flush_i           empty the queue; wins over push and pop
//   head_o            head entry (stale contents when empty)
//   count_o, empty_o  occupancy
module fetch_fifo
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic            full;
  logic            do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CntW'(DEPTH));
    empty_o  = (cnt_q == '0);
    count_o  = cnt_q;
    head_o   = mem_q[rd_ptr_q];
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap modulo DEPTH for free since DEPTH is a power of two.
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // The stall logic upstream reserves a slot for every issued fetch, so a
  // push can never land on a full queue.
  push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full));

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer between the PC/ROM fetch path and ID.
// Pairs each synchronous-ROM word with the PC that fetched it, queues the pairs,
// presents the head to ID and stalls the PC so it never outruns free space.
// Ports:
//   clk, rst (async, active low)
//   rom_en, addr        registered ROM enable / fetch address from the PC
//   rom_data            ROM word, valid the cycle after addr
//   stall_req           other PC stall sources; stall_pc drives the PC stall
//   flush               drop queued and in-flight fetches
//   stall_id            ID cannot accept this cycle
//   id_valid/id_pc/id_inst  head entry presented to ID
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = ADDR_BUS,
  parameter int unsigned INST_W = INST_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              stall_req,
  output logic              stall_pc,
  input  logic              flush,
  input  logic              stall_id,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam int unsigned EntW = ADDR_W + INST_W;

  logic              new_q, new_d;
  logic              first_q, first_d;
  logic              if_vld_q, if_vld_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              issue, push, pop;
  logic [CntW-1:0]   count;
  logic [OccW-1:0]   occupancy;
  logic              empty;
  logic [EntW-1:0]   head;

  always_comb begin
    // first_q holds rom_en from the last edge; a fresh rise of rom_en means
    // the PC has put out an address no edge has accepted yet.
    issue     = (rom_en == CHIP_ENABLE) & (new_q | ~first_q);
    // Count the queue, the in-flight word and this cycle's issue. pop is left
    // out on purpose so stall_id has no combinational path to stall_pc.
    occupancy = OccW'(count) + OccW'(if_vld_q) + OccW'(issue);
    stall_pc  = stall_req | (occupancy >= OccW'(DEPTH));
    push      = if_vld_q;
    id_valid  = ~empty;
    pop       = id_valid & ~stall_id;
    id_pc     = head[EntW-1:INST_W];
    id_inst   = head[INST_W-1:0];

    new_d    = rom_en & ~stall_pc;
    first_d  = rom_en;
    if_vld_d = issue;
    if_pc_d  = issue ? addr : if_pc_q;
    if (flush) begin
      // The PC loads the redirect on this edge; issue it next cycle.
      new_d    = 1'b1;
      if_vld_d = CHIP_DISABLE;
      if_pc_d  = if_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      new_q    <= 1'b0;
      first_q  <= 1'b0;
      if_vld_q <= 1'b0;
      if_pc_q  <= ADDR_W'(ZERO_WORD);
    end else begin
      new_q    <= new_d;
      first_q  <= first_d;
      if_vld_q <= if_vld_d;
      if_pc_q  <= if_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EntW)
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  ({if_pc_q, rom_data}),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

  localparam int NEXP = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en;
  logic [31:0] addr;
  logic [31:0] rom_data = '0;
  logic        stall_req = 1'b0;
  logic        stall_pc;
  logic        flush = 1'b0;
  logic        stall_id = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic [31:0] br_from  = 32'hFFFF_FFFF;
  logic [31:0] br_to    = 32'h0;
  logic [31:0] redirect = 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  int n_got    = 0;

  // Session A: reset release, ID stall at 0x8, stall_req at 0x10, branch 0x24->0x100.
  // Session B (after mid-stream reset): up to 0x2C, flush while 0x30 is held, redirect 0x200.
  logic [31:0] exp_pc [NEXP] = '{
    32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h018, 32'h01C,
    32'h020, 32'h024, 32'h100, 32'h104,
    32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h018, 32'h01C,
    32'h020, 32'h024, 32'h028, 32'h02C,
    32'h200, 32'h204, 32'h208, 32'h20C
  };

  always #5 clk = ~clk;

  if_fetch_buffer #(
    .DEPTH  (2),
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_en    (rom_en),
    .addr      (addr),
    .rom_data  (rom_data),
    .stall_req (stall_req),
    .stall_pc  (stall_pc),
    .flush     (flush),
    .stall_id  (stall_id),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1300_0000 + a * 32'd3;
  endfunction

  // PC model: enable rises on the first edge after reset, then steps by 4
  // unless stalled; flush loads the redirect, br_from jumps to br_to.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_en <= 1'b0;
      addr   <= 32'h0;
    end else if (!rom_en) begin
      rom_en <= 1'b1;
      addr   <= 32'h0;
    end else if (flush) begin
      addr <= redirect;
    end else if (!stall_pc) begin
      addr <= (addr == br_from) ? br_to : addr + 32'd4;
    end
  end

  // Synchronous ROM.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: observed=%0h required=%0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted head entry must be the next expected PC with its ROM word.
  always @(negedge clk) begin
    if (rst && id_valid && !stall_id) begin
      check("id_inst", id_inst, rom_word(id_pc));
      if (n_got < NEXP) check("id_pc_seq", id_pc, exp_pc[n_got]);
      n_got++;
    end
  end

  initial begin
    bit found;
    bit sp_seen;

    // Reset state.
    step();
    step();
    check("rst_valid", id_valid, 0);
    check("rst_pc", id_pc, 0);
    check("rst_inst", id_inst, 0);
    check("rst_stall_lo", stall_pc, 0);
    stall_req = 1'b1;
    #1;
    check("rst_stall_hi", stall_pc, 1);
    stall_req = 1'b0;
    br_from = 32'h24;
    br_to   = 32'h100;
    rst     = 1'b1;

    // First-fetch latency.
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rom_en) begin
        found = 1;
        break;
      end
    end
    check("rom_en_rise", found, 1);
    check("lat_k0", id_valid, 0);
    step();
    check("lat_k1", id_valid, 0);
    step();
    check("lat_k2_valid", id_valid, 1);
    check("lat_k2_pc", id_pc, 32'h0);

    // ID stall for 5 cycles starting when 0x8 is shown.
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (id_valid && id_pc == 32'h8) begin
        found = 1;
        break;
      end
      step();
    end
    check("see_08", found, 1);
    stall_id = 1'b1;
    sp_seen  = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_pc", id_pc, 32'h8);
      check("hold_vld", id_valid, 1);
      if (i < 2) sp_seen = sp_seen | stall_pc;
      step();
    end
    stall_id = 1'b0;
    check("stall_pc_rise", sp_seen, 1);

    // 3-cycle stall_req while the PC sits at 0x10.
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (addr == 32'h10) begin
        found = 1;
        break;
      end
      step();
    end
    check("see_addr_10", found, 1);
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sreq_stall", stall_pc, 1);
      step();
      check("sreq_hold", addr, 32'h10);
    end
    stall_req = 1'b0;

    // Run through the branch; reset when 0x108 is presented.
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if (id_valid && id_pc == 32'h108) begin
        found = 1;
        break;
      end
      step();
    end
    check("see_108", found, 1);
    check("a_count", n_got, 12);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", id_valid, 0);
    check("mid_rst_pc", id_pc, 0);
    check("mid_rst_inst", id_inst, 0);
    check("mid_rst_stall", stall_pc, 0);
    br_from = 32'hFFFF_FFFF;
    step();
    step();
    rst = 1'b1;

    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (id_valid) begin
        found = 1;
        break;
      end
      step();
    end
    check("b_valid", found, 1);
    check("b_first_pc", id_pc, 32'h0);

    // Fill the queue behind 0x30, then flush with a redirect to 0x200.
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if (id_valid && id_pc == 32'h30) begin
        found = 1;
        break;
      end
      step();
    end
    check("see_30", found, 1);
    stall_id = 1'b1;
    step();
    step();
    step();
    check("full_pc", id_pc, 32'h30);
    check("full_stall", stall_pc, 1);
    check("b_count", n_got, 24);
    redirect = 32'h200;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    stall_id = 1'b0;
    check("flush_vld", id_valid, 0);

    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (n_got >= NEXP) begin
        found = 1;
        break;
      end
      step();
    end
    check("stream_done", found, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
